// File: rtl/stream_align_pkg.sv
// Shared defaults and elaboration helpers for the stream pair aligner.
package stream_align_pkg;

    localparam int DEF_DATA_WIDTH_A = 16;
    localparam int DEF_DATA_WIDTH_B = 16;
    localparam int DEF_MAX_SKEW     = 8;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/align_fifo.sv
// Show-ahead synchronous FIFO with level count and sticky overflow flag.
// A push into a full FIFO is still accepted when the same cycle pops.
module align_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, push_ok, pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign pop_ok  = pop & !empty;
    assign push_ok = push & (!full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      level <= level + 1'b1;
            else if (!push_ok && pop_ok) level <= level - 1'b1;
            if (push && !push_ok) ovf <= 1'b1;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stream_pair_align.sv
// Re-pairs two valid-tagged streams of unequal path latency; each side waits
// in its own FIFO and a pair pops only when both sides hold data.
module stream_pair_align
    import stream_align_pkg::*;
#(
    parameter int DATA_WIDTH_A = DEF_DATA_WIDTH_A,
    parameter int DATA_WIDTH_B = DEF_DATA_WIDTH_B,
    parameter int MAX_SKEW     = DEF_MAX_SKEW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_a_valid,
    input  logic [DATA_WIDTH_A-1:0]   i_a_data,
    input  logic                      i_b_valid,
    input  logic [DATA_WIDTH_B-1:0]   i_b_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_WIDTH_A-1:0]   o_a_data,
    output logic [DATA_WIDTH_B-1:0]   o_b_data,
    output logic [$clog2(MAX_SKEW):0] o_lvl_a,
    output logic [$clog2(MAX_SKEW):0] o_lvl_b,
    output logic                      o_ovf_a,
    output logic                      o_ovf_b
);
    localparam int LVL_W = $clog2(MAX_SKEW) + 1;

    generate
        if (!is_pow2(MAX_SKEW) || MAX_SKEW < 2) begin : g_bad_skew
            $error("MAX_SKEW must be a power of 2 and >= 2");
        end
    endgenerate

    logic                    clr, pop, empty_a, empty_b;
    logic [DATA_WIDTH_A-1:0] head_a;
    logic [DATA_WIDTH_B-1:0] head_b;
    logic [LVL_W-1:0]        lvl_a, lvl_b;

    assign clr     = !rst_n | i_clr;
    assign pop     = !empty_a & !empty_b & (!o_valid | i_ready);
    assign o_lvl_a = lvl_a;
    assign o_lvl_b = lvl_b;

    align_fifo #(.WIDTH(DATA_WIDTH_A), .DEPTH(MAX_SKEW)) u_fifo_a (
        .clk(clk), .clr(clr), .push(i_a_valid), .din(i_a_data), .pop(pop),
        .dout(head_a), .empty(empty_a), .level(lvl_a), .ovf(o_ovf_a)
    );

    align_fifo #(.WIDTH(DATA_WIDTH_B), .DEPTH(MAX_SKEW)) u_fifo_b (
        .clk(clk), .clr(clr), .push(i_b_valid), .din(i_b_data), .pop(pop),
        .dout(head_b), .empty(empty_b), .level(lvl_b), .ovf(o_ovf_b)
    );

    // Output register: holds while stalled, drops valid once consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (clr) begin
            o_valid  <= 1'b0;
            o_a_data <= '0;
            o_b_data <= '0;
        end else if (pop) begin
            o_valid  <= 1'b1;
            o_a_data <= head_a;
            o_b_data <= head_b;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_pair_align.sv
// Self-checking bench: hand-derived vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_stream_pair_align;
    localparam int DW = 16;
    localparam int SK = 8;
    localparam int LW = $clog2(SK) + 1;

    logic          clk = 1'b0;
    logic          rst_n, i_clr, i_a_valid, i_b_valid, i_ready;
    logic [DW-1:0] i_a_data, i_b_data, o_a_data, o_b_data;
    logic          o_valid, o_ovf_a, o_ovf_b;
    logic [LW-1:0] o_lvl_a, o_lvl_b;

    stream_pair_align #(.DATA_WIDTH_A(DW), .DATA_WIDTH_B(DW), .MAX_SKEW(SK)) dut (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
        .i_a_valid(i_a_valid), .i_a_data(i_a_data),
        .i_b_valid(i_b_valid), .i_b_data(i_b_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_a_data(o_a_data), .o_b_data(o_b_data),
        .o_lvl_a(o_lvl_a), .o_lvl_b(o_lvl_b),
        .o_ovf_a(o_ovf_a), .o_ovf_b(o_ovf_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    // Reference model: one queue per side plus the output pair.
    logic [DW-1:0] mqa[$], mqb[$];
    logic          m_v, m_ovfa, m_ovfb;
    logic [DW-1:0] m_a, m_b;

    // Pairs accepted by the consumer, with the cycle they were taken.
    logic [DW-1:0] acc_a[$], acc_b[$];
    int            acc_t[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic v, input logic oa, input logic ob,
                                         input logic [LW-1:0] la, input logic [LW-1:0] lb,
                                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        // Payload is only meaningful while valid.
        return {21'd0, v, oa, ob, la, lb, (v ? a : 16'd0), (v ? b : 16'd0)};
    endfunction

    task automatic model_step();
        bit pop;
        if (!rst_n || i_clr) begin
            mqa.delete(); mqb.delete();
            m_v = 0; m_a = 0; m_b = 0; m_ovfa = 0; m_ovfb = 0;
        end else begin
            pop = (mqa.size() != 0) && (mqb.size() != 0) && (!m_v || i_ready);
            if (pop) begin
                m_a = mqa.pop_front();
                m_b = mqb.pop_front();
                m_v = 1;
            end else if (i_ready) begin
                m_v = 0;
            end
            if (i_a_valid) begin
                if (mqa.size() < SK) mqa.push_back(i_a_data);
                else m_ovfa = 1;
            end
            if (i_b_valid) begin
                if (mqb.size() < SK) mqb.push_back(i_b_data);
                else m_ovfb = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic av, input logic [DW-1:0] ad,
                       input logic bv, input logic [DW-1:0] bd, input logic rdy);
        rst_n = r; i_clr = c; i_a_valid = av; i_a_data = ad;
        i_b_valid = bv; i_b_data = bd; i_ready = rdy;
        if (o_valid && rdy && r && !c) begin
            acc_a.push_back(o_a_data);
            acc_b.push_back(o_b_data);
            acc_t.push_back(cycle);
        end
        @(posedge clk);
        model_step();
        cycle++;
        #1;
        check("model", pack(o_valid, o_ovf_a, o_ovf_b, o_lvl_a, o_lvl_b, o_a_data, o_b_data),
              pack(m_v, m_ovfa, m_ovfb, LW'(mqa.size()), LW'(mqb.size()), m_a, m_b));
    endtask

    task automatic flush();
        cyc(1, 1, 0, 0, 0, 0, 1);
        acc_a.delete(); acc_b.delete(); acc_t.delete();
    endtask

    typedef struct {
        logic r, c, av; logic [DW-1:0] ad; logic bv; logic [DW-1:0] bd; logic rdy;
        logic ev; logic [DW-1:0] ea, eb; logic [LW-1:0] ela, elb; logic eoa, eob;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int peak, k, lvl0;
        logic [DW-1:0] hold_a, hold_b;
        rst_n = 0; i_clr = 0; i_a_valid = 0; i_b_valid = 0; i_ready = 0;
        i_a_data = 0; i_b_data = 0;

        //          r  c  av ad       bv bd       rdy  ev ea       eb       la lb oa ob
        tbl[0]  = '{0, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 16'h0001, 1, 16'h1001, 1,  0, 16'h0000, 16'h0000, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 1, 16'h0002, 1, 16'h1002, 1,  1, 16'h0001, 16'h1001, 1, 1, 0, 0};
        tbl[6]  = '{1, 0, 1, 16'h0003, 1, 16'h1003, 1,  1, 16'h0002, 16'h1002, 1, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0003, 16'h1003, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 16'h0010, 0, 16'h0000, 1,  0, 16'h0000, 16'h0000, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 16'h0011, 0, 16'h0000, 1,  0, 16'h0000, 16'h0000, 2, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 16'h0000, 1, 16'h2010, 1,  0, 16'h0000, 16'h0000, 2, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0010, 16'h2010, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0010, 16'h2010, 1, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 16'h0000, 1, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].c, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].rdy);
            check($sformatf("vec%0d", i),
                  pack(o_valid, o_ovf_a, o_ovf_b, o_lvl_a, o_lvl_b, o_a_data, o_b_data),
                  pack(tbl[i].ev, tbl[i].eoa, tbl[i].eob, tbl[i].ela, tbl[i].elb, tbl[i].ea, tbl[i].eb));
        end

        // Skew 5: the pop lags the first B write by one edge, so A peaks at skew+1.
        flush();
        peak = 0;
        for (int t = 0; t < 30; t++) begin
            cyc(1, 0, t < 20, DW'(t), (t >= 5) && (t < 25), DW'(16'h1000 + t - 5), 1);
            if (int'(o_lvl_a) > peak) peak = int'(o_lvl_a);
        end
        check("skew_peak", 64'(peak), 64'd6);
        check("skew_ovf", {63'd0, o_ovf_a}, 64'd0);
        check("skew_count", 64'(acc_a.size()), 64'd20);
        for (int i = 0; i < acc_a.size(); i++) begin
            check("skew_pair", {32'(acc_a[i]), 32'(acc_b[i])}, {32'(i), 32'(16'h1000 + i)});
            if (i > 0) check("skew_gap", 64'(acc_t[i] - acc_t[i-1]), 64'd1);
        end

        // Overflow: 10 A-only samples into depth 8, then 8 B samples.
        flush();
        for (int t = 0; t < 10; t++) cyc(1, 0, 1, DW'(t), 0, 0, 1);
        check("ovf_lvl", 64'(o_lvl_a), 64'd8);
        check("ovf_flag", {62'd0, o_ovf_a, o_ovf_b}, 64'd2);
        for (int t = 0; t < 8; t++) cyc(1, 0, 0, 0, 1, DW'(16'h0100 + t), 1);
        for (int t = 0; t < 4; t++) cyc(1, 0, 0, 0, 0, 0, 1);
        check("ovf_count", 64'(acc_a.size()), 64'd8);
        for (int i = 0; i < acc_a.size(); i++)
            check("ovf_data", {32'(acc_a[i]), 32'(acc_b[i])}, {32'(i), 32'(16'h0100 + i)});

        // Backpressure: 3 stalled cycles while both streams keep arriving.
        flush();
        k = 0;
        for (int t = 0; t < 4; t++) begin cyc(1, 0, 1, DW'(k), 1, DW'(16'h4000 + k), 1); k++; end
        lvl0 = int'(o_lvl_a);
        hold_a = o_a_data; hold_b = o_b_data;
        for (int t = 0; t < 3; t++) begin
            cyc(1, 0, 1, DW'(k), 1, DW'(16'h4000 + k), 0); k++;
            check("bp_hold", {31'd0, o_valid, hold_a, hold_b}, {31'd1, o_a_data, o_b_data});
        end
        check("bp_lvl", {32'(o_lvl_a), 32'(o_lvl_b)}, {32'(lvl0 + 3), 32'(lvl0 + 3)});
        for (int t = 0; t < 8; t++) cyc(1, 0, 0, 0, 0, 0, 1);
        check("bp_count", 64'(acc_a.size()), 64'(k));
        for (int i = 0; i < acc_a.size(); i++)
            check("bp_order", {32'(acc_a[i]), 32'(acc_b[i])}, {32'(i), 32'(16'h4000 + i)});

        // Mid-stream clear with lvl_a=3 and a pending output pair.
        flush();
        cyc(1, 0, 1, 16'h0050, 1, 16'h0060, 0);
        cyc(1, 0, 1, 16'h0051, 0, 0, 0);
        cyc(1, 0, 1, 16'h0052, 0, 0, 0);
        cyc(1, 0, 1, 16'h0053, 0, 0, 0);
        check("clr_pre", {31'd0, o_valid, 32'(o_lvl_a)}, {31'd1, 32'd3});
        cyc(1, 1, 1, 16'hDEAD, 1, 16'hBEEF, 1);
        check("clr_zero", {o_valid, o_ovf_a, o_ovf_b, 29'(o_lvl_a), 16'(o_lvl_b), o_a_data},
              64'd0);
        cyc(1, 0, 1, 16'h00AA, 1, 16'h00BB, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        check("clr_repair", {31'd0, o_valid, o_a_data, o_b_data}, {31'd1, 16'h00AA, 16'h00BB});

        // Randomized traffic with per-phase bias to exercise skew, overflow and stalls.
        for (int ph = 0; ph < 8; ph++) begin
            int pa, pb, pr;
            pa = $urandom_range(1, 4); pb = $urandom_range(1, 4); pr = $urandom_range(1, 4);
            for (int t = 0; t < 60; t++)
                cyc(1, ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) < pa), DW'($urandom),
                    ($urandom_range(0, 4) < pb), DW'($urandom), ($urandom_range(0, 4) < pr));
        end
        cyc(0, 0, 1, 16'h1234, 1, 16'h5678, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
